// File: rtl/dm_lsu.sv
// ---------------------------------------------------------------------------
// dm_lsu : load/store unit driving a single-port data memory.
//
// Accepts byte/half/word loads and stores over a valid/ready handshake,
// performs lane extraction with sign/zero extension on loads, read-modify-write
// for sub-word stores, and alignment/range checking. Each accepted request
// produces exactly one response.
//
// Build option:
//   DM_LSU_SUBWORD_STORE_EN  defined     -> byte/half stores go through RMW.
//                            not defined -> byte/half stores answer with an
//                                           error and never touch memory.
//
// Ports:
//   clk             rising-edge clock
//   Reset           asynchronous active-low reset
//   ReqValid/ReqReady/ReqWrite/ReqSize/ReqSigned/ReqAddress/ReqData
//                   request channel (size: 00 byte, 01 half, 10 word)
//   RespValid/RespReady/RespData/RespError
//                   response channel
//   DmWriteEnable/DmWriteAddress/DmWriteData/DmReadAddress/DmReadData
//                   data memory port (combinational read)
//   dbg_state       current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The requester holds its request until it is taken; a response
// stays valid and unchanged until the edge where RespReady is high.
// ---------------------------------------------------------------------------
module dm_lsu #(
   parameter int DM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [1:0]  ReqSize,
   input  logic        ReqSigned,
   input  logic [31:0] ReqAddress,
   input  logic [31:0] ReqData,
   output logic        RespValid,
   input  logic        RespReady,
   output logic [31:0] RespData,
   output logic        RespError,
   output logic        DmWriteEnable,
   output logic [31:0] DmWriteAddress,
   output logic [31:0] DmWriteData,
   output logic [31:0] DmReadAddress,
   input  logic [31:0] DmReadData,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      STORE = 3'd2,
      RESP  = 3'd3
`ifdef DM_LSU_SUBWORD_STORE_EN
      , RMW = 3'd4
`endif
   } state_t;

   localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS);

   state_t      state, state_n;
   logic        ready_q;      // holds ReqReady low for the first cycle after reset
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [31:0] wbuf_q;       // store data, later the merged word
   logic [31:0] resp_data_q;
   logic        resp_error_q;

   logic        accept;
   logic        req_err;
   logic [7:0]  lane8;
   logic [15:0] lane16;
   logic [31:0] load_val;
   logic [31:0] merged;
   logic [31:0] word_addr;

   assign accept    = ReqReady && ReqValid;
   assign word_addr = {addr_q[31:2], 2'b00};

   // Request checking on the live request inputs (only meaningful in IDLE).
   always_comb begin
      req_err = 1'b0;
      if (ReqSize == 2'b11)                                 req_err = 1'b1;
      if (ReqSize == 2'b01 && ReqAddress[0])                req_err = 1'b1;
      if (ReqSize == 2'b10 && ReqAddress[1:0] != 2'b00)     req_err = 1'b1;
      if ({2'b00, ReqAddress[31:2]} >= DM_LIMIT)            req_err = 1'b1;
`ifndef DM_LSU_SUBWORD_STORE_EN
      if (ReqWrite && ReqSize != 2'b10)                     req_err = 1'b1;
`endif
   end

   // Little-endian lane extraction and extension for loads.
   always_comb begin
      lane8    = DmReadData[{addr_q[1:0], 3'b000} +: 8];
      lane16   = DmReadData[{addr_q[1], 4'b0000} +: 16];
      load_val = DmReadData;
      case (size_q)
         2'b00:   load_val = signed_q ? {{24{lane8[7]}}, lane8} : {24'd0, lane8};
         2'b01:   load_val = signed_q ? {{16{lane16[15]}}, lane16} : {16'd0, lane16};
         default: load_val = DmReadData;
      endcase
   end

   // Sub-word merge: the new lane comes from the right-aligned store data.
   always_comb begin
      merged = DmReadData;
      if (size_q == 2'b00)
         merged[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)
                  state_n = RESP;
               else if (!ReqWrite)
                  state_n = LOAD;
`ifdef DM_LSU_SUBWORD_STORE_EN
               else if (ReqSize == 2'b10)
                  state_n = STORE;
               else
                  state_n = RMW;
`else
               else
                  state_n = STORE;
`endif
            end
         end
         LOAD:  state_n = RESP;
`ifdef DM_LSU_SUBWORD_STORE_EN
         RMW:   state_n = STORE;
`endif
         STORE: state_n = RESP;
         RESP:  if (RespReady) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state        <= IDLE;
         ready_q      <= 1'b0;
         addr_q       <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         wbuf_q       <= '0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state   <= state_n;
         ready_q <= 1'b1;
         if (accept) begin
            addr_q       <= ReqAddress;
            size_q       <= ReqSize;
            signed_q     <= ReqSigned;
            wbuf_q       <= ReqData;
            resp_data_q  <= '0;
            resp_error_q <= req_err;
         end
         if (state == LOAD)
            resp_data_q <= load_val;
`ifdef DM_LSU_SUBWORD_STORE_EN
         if (state == RMW)
            wbuf_q <= merged;
`endif
      end
   end

   always_comb begin
      ReqReady       = (state == IDLE) && ready_q;
      RespValid      = (state == RESP);
      RespData       = resp_data_q;
      RespError      = resp_error_q;
      DmWriteEnable  = (state == STORE);
      DmWriteAddress = (state == STORE) ? word_addr : 32'd0;
      DmWriteData    = (state == STORE) ? wbuf_q : 32'd0;
      DmReadAddress  = 32'd0;
      if (state == LOAD)
         DmReadAddress = word_addr;
`ifdef DM_LSU_SUBWORD_STORE_EN
      if (state == RMW)
         DmReadAddress = word_addr;
`endif
      dbg_state      = state;
   end

   // merged is only consumed by the RMW path.
`ifndef DM_LSU_SUBWORD_STORE_EN
   logic unused_merged;
   assign unused_merged = ^merged;
`endif

endmodule

// File: tb/tb_dm_lsu.sv
// ---------------------------------------------------------------------------
// tb_dm_lsu : directed, table-driven bench for dm_lsu with a behavioural
// data memory, plus hand-written sequences for reset, back-pressure and
// reset during a store.
// ---------------------------------------------------------------------------
module tb_dm_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_address;
   logic [31:0] req_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_error;
   logic        dm_we;
   logic [31:0] dm_waddr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_raddr;
   logic [31:0] dm_rdata;
   logic [2:0]  dbg_state;

   int tests = 0;
   int fails = 0;

   dm_lsu #(.DM_WORDS(1024)) dut (
      .clk(clk), .Reset(rst_n),
      .ReqValid(req_valid), .ReqReady(req_ready), .ReqWrite(req_write),
      .ReqSize(req_size), .ReqSigned(req_signed), .ReqAddress(req_address),
      .ReqData(req_data),
      .RespValid(resp_valid), .RespReady(resp_ready), .RespData(resp_data),
      .RespError(resp_error),
      .DmWriteEnable(dm_we), .DmWriteAddress(dm_waddr), .DmWriteData(dm_wdata),
      .DmReadAddress(dm_raddr), .DmReadData(dm_rdata),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural memory and write monitor
   logic [31:0] mem [1024];
   int          wr_count = 0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;

   always_comb dm_rdata = mem[dm_raddr[11:2]];

   always @(posedge clk) begin
      if (dm_we) begin
         mem[dm_waddr[11:2]] = dm_wdata;
         wr_count++;
         last_waddr = dm_waddr;
         last_wdata = dm_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;   // edges after the accept edge until RespValid
      int          exp_wr;    // number of memory writes
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic wr, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_data, input logic exp_err,
                      input int exp_lat, input int exp_wr, input logic [31:0] exp_wdata);
      vec_t v;
      v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.data = data;
      v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat;
      v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
      vq.push_back(v);
   endtask

   // Waits (bounded) for ReqReady at a falling edge, then presents the request.
   // Returns after the accept edge (+1 time unit) with ReqValid dropped.
   task automatic drive_req(input string name, input logic wr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] data);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
      req_address = addr; req_data = data;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      string nm;
      int lat;
      int wr0;
      nm  = $sformatf("v%0d", i);
      wr0 = wr_count;
      drive_req(nm, v.wr, v.size, v.sgn, v.addr, v.data);
      lat = 0;
      while (!resp_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      check({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
      check({nm, "_data"}, resp_data, v.exp_data);
      check({nm, "_err"}, 32'(resp_error), 32'(v.exp_err));
      check({nm, "_rdy_busy"}, 32'(req_ready), 32'd0);
      check({nm, "_wr_count"}, 32'(wr_count - wr0), 32'(v.exp_wr));
      if (v.exp_wr == 1) begin
         check({nm, "_waddr"}, last_waddr, {v.addr[31:2], 2'b00});
         check({nm, "_wdata"}, last_wdata, v.exp_wdata);
      end
      // RespReady already high: response lasts one cycle.
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({nm, "_resp_drop"}, 32'(resp_valid), 32'd0);
      check({nm, "_rdy_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] hold_data;
      logic [31:0] mem_before;
      int          wr0;

      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[4]    = 32'h80FF7F01;   // byte address 0x10
      mem[12]   = 32'h55667788;   // byte address 0x30
      mem[1023] = 32'hA5A55A5A;   // last word, byte address 0xFFC

      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_address = '0; req_data = '0; resp_ready = 1'b0;

      // reset state
      #12;
      check("rst_req_ready",  32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data",  resp_data, 32'd0);
      check("rst_resp_error", 32'(resp_error), 32'd0);
      check("rst_we",         32'(dm_we), 32'd0);
      check("rst_waddr",      dm_waddr, 32'd0);
      check("rst_wdata",      dm_wdata, 32'd0);
      check("rst_raddr",      dm_raddr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_rel_ready0", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("rst_rel_ready1", 32'(req_ready), 32'd1);

      // table: wr, size, sgn, addr, data, exp_data, exp_err, exp_lat, exp_wr, exp_wdata
      add(0, 2'b00, 1, 32'h10, 0, 32'h00000001, 0, 1, 0, 0);
      add(0, 2'b00, 1, 32'h11, 0, 32'h0000007F, 0, 1, 0, 0);
      add(0, 2'b00, 1, 32'h12, 0, 32'hFFFFFFFF, 0, 1, 0, 0);
      add(0, 2'b00, 1, 32'h13, 0, 32'hFFFFFF80, 0, 1, 0, 0);
      add(0, 2'b00, 0, 32'h13, 0, 32'h00000080, 0, 1, 0, 0);
      add(0, 2'b01, 1, 32'h12, 0, 32'hFFFF80FF, 0, 1, 0, 0);
      add(0, 2'b01, 0, 32'h10, 0, 32'h00007F01, 0, 1, 0, 0);
      add(0, 2'b01, 1, 32'h10, 0, 32'h00007F01, 0, 1, 0, 0);
      add(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, 0, 1, 1, 32'hDEADBEEF);
      add(0, 2'b10, 0, 32'h20, 0, 32'hDEADBEEF, 0, 1, 0, 0);
      add(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, 1, 1, 32'h11223344);
`ifdef DM_LSU_SUBWORD_STORE_EN
      add(1, 2'b00, 0, 32'h22, 32'hFFFFFFAB, 0, 0, 2, 1, 32'h11AB3344);
      add(1, 2'b01, 0, 32'h20, 32'h1234CDEF, 0, 0, 2, 1, 32'h11ABCDEF);
      add(0, 2'b10, 0, 32'h20, 0, 32'h11ABCDEF, 0, 1, 0, 0);
`else
      add(1, 2'b00, 0, 32'h22, 32'hFFFFFFAB, 0, 1, 0, 0, 0);
      add(1, 2'b01, 0, 32'h20, 32'h1234CDEF, 0, 1, 0, 0, 0);
      add(0, 2'b10, 0, 32'h20, 0, 32'h11223344, 0, 1, 0, 0);
`endif
      add(0, 2'b10, 0, 32'h21,   0, 0, 1, 0, 0, 0);   // misaligned word
      add(0, 2'b01, 1, 32'h23,   0, 0, 1, 0, 0, 0);   // misaligned half
      add(0, 2'b11, 0, 32'h20,   0, 0, 1, 0, 0, 0);   // reserved size
      add(0, 2'b10, 0, 32'h1000, 0, 0, 1, 0, 0, 0);   // word index 1024
      add(0, 2'b00, 0, 32'h1003, 0, 0, 1, 0, 0, 0);   // byte beyond range
      add(1, 2'b10, 0, 32'h1000, 32'h12345678, 0, 1, 0, 0, 0); // store out of range
      add(0, 2'b10, 0, 32'hFFC,  0, 32'hA5A55A5A, 0, 1, 0, 0); // last word
      add(0, 2'b00, 1, 32'hFFD,  0, 32'h0000005A, 0, 1, 0, 0);

      foreach (vq[i]) run_vec(i, vq[i]);

      // back-pressure: response held for 5 cycles with RespReady low
      drive_req("bp", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
      @(posedge clk); #1;
      check("bp_valid0", 32'(resp_valid), 32'd1);
      hold_data = 32'hFFFFFF80;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("bp_valid_c%0d", k), 32'(resp_valid), 32'd1);
         check($sformatf("bp_data_c%0d", k), resp_data, hold_data);
         check($sformatf("bp_ready_c%0d", k), 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("bp_release_valid", 32'(resp_valid), 32'd0);
      check("bp_release_ready", 32'(req_ready), 32'd1);

      // reset while the write strobe is up
      mem_before = mem[12];
      wr0 = wr_count;
`ifdef DM_LSU_SUBWORD_STORE_EN
      drive_req("rs", 1'b1, 2'b00, 1'b0, 32'h31, 32'h000000EE);
      @(posedge clk); #1;
`else
      drive_req("rs", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
`endif
      check("rs_we_before", 32'(dm_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rs_we",         32'(dm_we), 32'd0);
      check("rs_waddr",      dm_waddr, 32'd0);
      check("rs_wdata",      dm_wdata, 32'd0);
      check("rs_raddr",      dm_raddr, 32'd0);
      check("rs_ready",      32'(req_ready), 32'd0);
      check("rs_resp_valid", 32'(resp_valid), 32'd0);
      check("rs_resp_data",  resp_data, 32'd0);
      check("rs_resp_error", 32'(resp_error), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("rs_mem",        mem[12], mem_before);
      check("rs_wr_count",   32'(wr_count - wr0), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rs_rel_ready0", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("rs_rel_ready1", 32'(req_ready), 32'd1);
      check("rs_mem_after",  mem[12], mem_before);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
